// File: rtl/upper_imm_unit_if.sv
// Handshake and datapath signals of the upper-immediate unit: instruction issue,
// shared-ALU request/response and register writeback.
interface upper_imm_unit_if #(
   parameter int XLEN           = 32,
   parameter int REG_SELECT_LEN = 5
);
   logic                      start;
   logic                      ready;
   logic [31:0]               instruction;
   logic [XLEN-1:0]           program_counter;
   logic                      alu_req;
   logic                      alu_gnt;
   logic [XLEN-1:0]           alu_a;
   logic [XLEN-1:0]           alu_b;
   logic [2:0]                alu_op;
   logic                      alu_sig;
   logic [XLEN-1:0]           alu_out;
   logic                      alu_valid;
   logic                      wb_valid;
   logic                      wb_ready;
   logic [REG_SELECT_LEN-1:0] output_register;
   logic [XLEN-1:0]           output_register_data;
   logic                      illegal;

   modport master (
      output start, instruction, program_counter, alu_gnt, alu_out, alu_valid, wb_ready,
      input  ready, alu_req, alu_a, alu_b, alu_op, alu_sig, wb_valid, output_register,
             output_register_data, illegal
   );

   modport slave (
      input  start, instruction, program_counter, alu_gnt, alu_out, alu_valid, wb_ready,
      output ready, alu_req, alu_a, alu_b, alu_op, alu_sig, wb_valid, output_register,
             output_register_data, illegal
   );
endinterface

// File: rtl/upper_imm_unit.sv
// LUI/AUIPC execution unit: builds the upper immediate, borrows the shared ALU for
// AUIPC (PC + imm) and offers the result to writeback.
//
// state    | meaning
// IDLE     | ready for a new instruction
// ALU_REQ  | AUIPC operands presented, alu_req high, waiting for alu_gnt
// ALU_WAIT | ALU granted, waiting for alu_valid
// WB       | result offered on wb_valid (single dead cycle when LUI targets x0)
module upper_imm_unit #(
   parameter int XLEN           = 32,
   parameter int REG_SELECT_LEN = 5
) (
   input  logic            clk,
   input  logic            rst,
   upper_imm_unit_if.slave bus
);
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef enum logic [1:0] {S_IDLE, S_ALU_REQ, S_ALU_WAIT, S_WB} state_t;

   state_t          r_state;
   logic            r_ready;
   logic            r_alu_req;
   logic            r_wb_valid;
   logic            r_illegal;
   logic [XLEN-1:0] r_alu_a;
   logic [XLEN-1:0] r_alu_b;
   logic [XLEN-1:0] r_out_data;
   logic [4:0]      r_rd;
   logic [4:0]      r_out_reg;

   logic [6:0]      w_opcode;
   logic [4:0]      w_rd;
   logic [XLEN-1:0] w_imm;
   logic            w_alu_done;

   assign w_opcode = bus.instruction[6:0];
   assign w_rd     = bus.instruction[11:7];
   assign w_imm    = {{(XLEN-31){bus.instruction[31]}}, bus.instruction[30:12], 12'b0};

   // A result landing in the grant cycle skips ALU_WAIT entirely.
   assign w_alu_done = ((r_state == S_ALU_REQ) && bus.alu_gnt && bus.alu_valid) ||
                       ((r_state == S_ALU_WAIT) && bus.alu_valid);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ready    <= 1'b1;
         r_alu_req  <= 1'b0;
         r_wb_valid <= 1'b0;
         r_illegal  <= 1'b0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_out_data <= '0;
         r_rd       <= '0;
         r_out_reg  <= '0;
      end else begin
         r_illegal <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_rd <= w_rd;
                  if (w_opcode == OP_LUI) begin
                     r_state    <= S_WB;
                     r_ready    <= 1'b0;
                     r_wb_valid <= (w_rd != 5'd0);
                     r_out_reg  <= w_rd;
                     r_out_data <= (w_rd != 5'd0) ? w_imm : '0;
                  end else if (w_opcode == OP_AUIPC) begin
                     r_state   <= S_ALU_REQ;
                     r_ready   <= 1'b0;
                     r_alu_req <= 1'b1;
                     r_alu_a   <= bus.program_counter;
                     r_alu_b   <= w_imm;
                  end else begin
                     r_illegal <= 1'b1;
                  end
               end
            end
            S_ALU_REQ, S_ALU_WAIT: begin
               if (w_alu_done) begin
                  r_alu_req <= 1'b0;
                  r_alu_a   <= '0;
                  r_alu_b   <= '0;
                  if (r_rd != 5'd0) begin
                     r_state    <= S_WB;
                     r_wb_valid <= 1'b1;
                     r_out_reg  <= r_rd;
                     r_out_data <= bus.alu_out;
                  end else begin
                     r_state <= S_IDLE;
                     r_ready <= 1'b1;
                  end
               end else if ((r_state == S_ALU_REQ) && bus.alu_gnt) begin
                  r_state   <= S_ALU_WAIT;
                  r_alu_req <= 1'b0;
               end
            end
            S_WB: begin
               if (bus.wb_ready || !r_wb_valid) begin
                  r_state    <= S_IDLE;
                  r_ready    <= 1'b1;
                  r_wb_valid <= 1'b0;
                  r_out_reg  <= '0;
                  r_out_data <= '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready                = r_ready;
   assign bus.alu_req              = r_alu_req;
   assign bus.alu_a                = r_alu_a;
   assign bus.alu_b                = r_alu_b;
   assign bus.alu_op               = 3'b000;
   assign bus.alu_sig              = 1'b0;
   assign bus.wb_valid             = r_wb_valid;
   assign bus.output_register      = REG_SELECT_LEN'(r_out_reg);
   assign bus.output_register_data = r_out_data;
   assign bus.illegal              = r_illegal;
endmodule

// File: tb/tb_upper_imm_unit.sv
// Bench for upper_imm_unit: a 64-bit and a 32-bit instance run in lockstep from the
// same stimulus, results checked against a queue of expected writebacks.
module tb_upper_imm_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] instr;
   logic [63:0] pc;
   logic        gnt;
   logic        valid;
   logic        wb_ready;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] d64;
      logic [31:0] d32;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   upper_imm_unit_if #(.XLEN(64), .REG_SELECT_LEN(5)) b64 ();
   upper_imm_unit_if #(.XLEN(32), .REG_SELECT_LEN(5)) b32 ();

   assign b64.start           = start;
   assign b64.instruction     = instr;
   assign b64.program_counter = pc;
   assign b64.alu_gnt         = gnt;
   assign b64.alu_valid       = valid;
   assign b64.wb_ready        = wb_ready;
   assign b64.alu_out         = b64.alu_a + b64.alu_b;

   assign b32.start           = start;
   assign b32.instruction     = instr;
   assign b32.program_counter = pc[31:0];
   assign b32.alu_gnt         = gnt;
   assign b32.alu_valid       = valid;
   assign b32.wb_ready        = wb_ready;
   assign b32.alu_out         = b32.alu_a + b32.alu_b;

   upper_imm_unit #(.XLEN(64), .REG_SELECT_LEN(5)) u_dut64 (.clk(clk), .rst(rst), .bus(b64));
   upper_imm_unit #(.XLEN(32), .REG_SELECT_LEN(5)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] imm_of(input logic [31:0] ins);
      logic [63:0] v;
      v = {{32{ins[31]}}, ins[31:12], 12'h000};
      return v;
   endfunction

   // Offer one instruction; returns in the first cycle after the accepting edge.
   task automatic issue(input logic [31:0] ins, input logic [63:0] pc_v);
      exp_t e;
      int   budget;
      budget = 0;
      while (!b64.ready && budget < 20) begin
         step();
         budget++;
      end
      if (!b64.ready) begin
         check_eq("ready_timeout", 64'(b64.ready), 64'd1);
         return;
      end
      start = 1'b1;
      instr = ins;
      pc    = pc_v;
      if (ins[11:7] != 5'd0 && (ins[6:0] == 7'h37 || ins[6:0] == 7'h17)) begin
         e.rd  = ins[11:7];
         e.d64 = (ins[6:0] == 7'h37) ? imm_of(ins) : pc_v + imm_of(ins);
         e.d32 = e.d64[31:0];
         sb_q.push_back(e);
      end
      step();
      start = 1'b0;
   endtask

   // Play the shared ALU: hold off the grant, then deliver the result lat cycles later.
   task automatic alu_serve(input int stall, input int lat, input logic [63:0] exp_a,
                            input logic [63:0] exp_b);
      for (int i = 0; i < stall; i++) begin
         check_eq("stall_req", 64'(b64.alu_req), 64'd1);
         check_eq("stall_ready", 64'(b64.ready), 64'd0);
         check_eq("stall_wbv", 64'(b64.wb_valid), 64'd0);
         check_eq("stall_a", b64.alu_a, exp_a);
         check_eq("stall_b", b64.alu_b, exp_b);
         step();
      end
      check_eq("req", 64'(b64.alu_req), 64'd1);
      check_eq("req_a", b64.alu_a, exp_a);
      check_eq("req_b", b64.alu_b, exp_b);
      check_eq("req_a32", 64'(b32.alu_a), 64'(exp_a[31:0]));
      check_eq("req_op", 64'({b64.alu_sig, b64.alu_op}), 64'd0);
      gnt   = 1'b1;
      valid = (lat == 0);
      step();
      gnt   = 1'b0;
      valid = 1'b0;
      if (lat > 0) begin
         check_eq("wait_req", 64'(b64.alu_req), 64'd0);
         check_eq("wait_b", b64.alu_b, exp_b);
         for (int i = 1; i < lat; i++) step();
         valid = 1'b1;
         step();
         valid = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (!rst && b64.wb_valid && wb_ready) begin
         if (sb_q.size() == 0) begin
            check_eq("wb_unexpected", 64'(b64.wb_valid), 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check_eq("wb_rd", 64'(b64.output_register), 64'(mon_e.rd));
            check_eq("wb_data64", b64.output_register_data, mon_e.d64);
            check_eq("wb_valid32", 64'(b32.wb_valid), 64'd1);
            check_eq("wb_data32", 64'(b32.output_register_data), 64'(mon_e.d32));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rnd_pc;
      logic [31:0] rnd_ins;
      rst      = 1'b1;
      start    = 1'b1;
      instr    = 32'h123450B7;
      pc       = '0;
      gnt      = 1'b0;
      valid    = 1'b0;
      wb_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;

      // reset values, start offered during reset must be dropped
      check_eq("rst_ready", 64'(b64.ready), 64'd1);
      check_eq("rst_alu_req", 64'(b64.alu_req), 64'd0);
      check_eq("rst_wbv", 64'(b64.wb_valid), 64'd0);
      check_eq("rst_illegal", 64'(b64.illegal), 64'd0);
      check_eq("rst_alu_a", b64.alu_a, 64'd0);
      check_eq("rst_alu_b", b64.alu_b, 64'd0);
      check_eq("rst_out_reg", 64'(b64.output_register), 64'd0);
      check_eq("rst_out_data", b64.output_register_data, 64'd0);
      check_eq("rst_ready32", 64'(b32.ready), 64'd1);
      step();
      check_eq("rst_start_ignored", 64'(b64.wb_valid), 64'd0);

      // LUI, one-cycle latency
      issue(32'h123450B7, 64'h40);
      check_eq("lui_wbv", 64'(b64.wb_valid), 64'd1);
      check_eq("lui_alu_req", 64'(b64.alu_req), 64'd0);
      check_eq("lui_rd", 64'(b32.output_register), 64'd1);
      check_eq("lui_data32", 64'(b32.output_register_data), 64'h12345000);
      step();
      check_eq("lui_back_idle", 64'(b64.ready), 64'd1);

      // AUIPC with negative immediate wrapping to zero, two-cycle latency
      issue(32'hFFFFF117, 64'h1000);
      alu_serve(0, 0, 64'h1000, 64'hFFFFFFFFFFFFF000);
      check_eq("auipc_wbv", 64'(b64.wb_valid), 64'd1);
      check_eq("auipc_rd", 64'(b64.output_register), 64'd2);
      check_eq("auipc_data", b64.output_register_data, 64'd0);
      step();

      // grant stall then late result
      issue(32'h00010197, 64'h2000);
      alu_serve(5, 2, 64'h2000, 64'h10000);
      check_eq("stall_wbv_end", 64'(b64.wb_valid), 64'd1);
      step();

      // writeback backpressure with a start offered during the stall
      wb_ready = 1'b0;
      issue(32'hABCDE237, 64'h0);
      for (int i = 0; i < 3; i++) begin
         check_eq("bp_wbv", 64'(b64.wb_valid), 64'd1);
         check_eq("bp_rd", 64'(b64.output_register), 64'd4);
         check_eq("bp_data", b64.output_register_data, 64'hFFFFFFFFABCDE000);
         check_eq("bp_ready", 64'(b64.ready), 64'd0);
         start = 1'b1;
         instr = 32'h00001537;
         step();
      end
      start    = 1'b0;
      wb_ready = 1'b1;
      step();
      check_eq("bp_idle", 64'(b64.ready), 64'd1);
      step();
      check_eq("bp_no_extra", 64'(b64.wb_valid), 64'd0);

      // reset while waiting for the ALU result
      issue(32'h00002297, 64'h3000);
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      check_eq("mid_wait_req", 64'(b64.alu_req), 64'd0);
      rst = 1'b1;
      sb_q.delete();
      step();
      rst = 1'b0;
      check_eq("mid_rst_ready", 64'(b64.ready), 64'd1);
      check_eq("mid_rst_alu_a", b64.alu_a, 64'd0);
      valid = 1'b1;
      step();
      valid = 1'b0;
      check_eq("mid_rst_wbv", 64'(b64.wb_valid), 64'd0);
      check_eq("mid_rst_ready2", 64'(b64.ready), 64'd1);

      // illegal opcode
      issue(32'h002081B3, 64'h0);
      check_eq("ill_pulse", 64'(b64.illegal), 64'd1);
      check_eq("ill_ready", 64'(b64.ready), 64'd1);
      check_eq("ill_alu_req", 64'(b64.alu_req), 64'd0);
      step();
      check_eq("ill_clear", 64'(b64.illegal), 64'd0);

      // destination x0
      issue(32'h12345037, 64'h0);
      check_eq("x0_lui_wbv", 64'(b64.wb_valid), 64'd0);
      step();
      check_eq("x0_lui_ready", 64'(b64.ready), 64'd1);
      issue(32'h00001017, 64'h10);
      alu_serve(0, 1, 64'h10, 64'h1000);
      check_eq("x0_auipc_wbv", 64'(b64.wb_valid), 64'd0);
      check_eq("x0_auipc_ready", 64'(b64.ready), 64'd1);

      // random mix of LUI and AUIPC
      for (int n = 0; n < 24; n++) begin
         rnd_pc  = {$urandom, $urandom};
         rnd_ins = {20'($urandom), 5'($urandom_range(1, 31)),
                    ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17};
         issue(rnd_ins, rnd_pc);
         if (rnd_ins[6:0] == 7'h17)
            alu_serve($urandom_range(0, 3), $urandom_range(0, 2), rnd_pc, imm_of(rnd_ins));
         check_eq("rnd_wbv", 64'(b64.wb_valid), 64'd1);
         step();
      end

      step();
      check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/upper_imm_unit.md
UPPER_IMM_UNIT -- requirements
Module: upper_imm_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the datapath width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter REG_SELECT_LEN, default 5, giving the register-select width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: an instruction is offered this cycle.
REQ-006 The block SHALL have port ready, output, 1 bit: the block accepts start this cycle.
REQ-007 The block SHALL have port instruction, input, 32 bits: RV32 instruction word.
REQ-008 The block SHALL have port program_counter, input, XLEN bits: PC of that instruction.
REQ-009 The block SHALL have port alu_req, output, 1 bit: request for the shared ALU.
REQ-010 The block SHALL have port alu_gnt, input, 1 bit: ALU granted this cycle.
REQ-011 The block SHALL have ports alu_a and alu_b, output, XLEN bits each: ALU operands.
REQ-012 The block SHALL have ports alu_op (output, 3 bits) and alu_sig (output, 1 bit): ALU operation select.
REQ-013 The block SHALL have ports alu_out (input, XLEN bits) and alu_valid (input, 1 bit): ALU result and its qualifier.
REQ-014 The block SHALL have ports wb_valid (output, 1 bit) and wb_ready (input, 1 bit): writeback handshake.
REQ-015 The block SHALL have ports output_register (output, REG_SELECT_LEN bits) and output_register_data (output, XLEN bits): destination register and value.
REQ-016 The block SHALL have port illegal, output, 1 bit: one-cycle pulse when an accepted opcode is neither LUI nor AUIPC.

Function
REQ-017 The block SHALL implement states IDLE, ALU_REQ, ALU_WAIT, and WB; ready SHALL be 1 only in IDLE.
REQ-018 Acceptance SHALL occur when start and ready are both 1; the block SHALL latch instruction, program_counter, rd = instruction[11:7], and imm.
REQ-019 imm SHALL equal {instruction[31:12], 12'b0} sign-extended from bit 31 to XLEN.
REQ-020 For LUI (opcode[6:0] = 0110111), the block SHALL go IDLE -> WB with data = imm, with no ALU request.
REQ-021 For AUIPC (opcode 0010111), the block SHALL go IDLE -> ALU_REQ.
REQ-022 In ALU_REQ and ALU_WAIT, the block SHALL hold alu_a = latched PC, alu_b = imm, alu_op = 000, alu_sig = 0.
REQ-023 In ALU_REQ, alu_req SHALL be 1; on alu_gnt the block SHALL go to ALU_WAIT. If alu_valid arrives in the same cycle as alu_gnt, the block SHALL capture alu_out and go directly to WB.
REQ-024 In ALU_WAIT, on alu_valid the block SHALL capture alu_out and go to WB; alu_req SHALL be 0 in ALU_WAIT.
REQ-025 Sum width: alu_out is XLEN bits, and carry-out SHALL be discarded (PC + imm wraps modulo 2^XLEN).
REQ-026 In WB, wb_valid SHALL be 1, with output_register and output_register_data held stable until the cycle wb_ready = 1; the block SHALL then return to IDLE.
REQ-027 rd = 0: the block SHALL skip WB entirely, returning to IDLE after the result (LUI: one cycle; AUIPC: after alu_valid), with wb_valid never asserted.
REQ-028 Any other opcode: illegal SHALL pulse for one cycle, the state SHALL remain IDLE, and no ALU request or writeback SHALL occur.
REQ-029 Outside their active states, alu_a, alu_b, alu_op, alu_sig, and output_register_data SHALL be driven to 0; no output is ever high-impedance.
REQ-030 Latency (accept to wb_valid) SHALL be: LUI 1 cycle; AUIPC with alu_gnt and alu_valid both in the first ALU_REQ cycle, 2 cycles.
REQ-031 start while not ready SHALL be ignored; the latched instruction SHALL NOT change until the block returns to IDLE.

Reset
REQ-032 When rst is 1 at a clock edge, the next state SHALL be IDLE in any state, including mid-ALU or mid-WB. A pending ALU result SHALL be dropped.
REQ-033 After reset: ready = 1; alu_req = 0; wb_valid = 0; illegal = 0; every data and select output = 0.
REQ-034 rst SHALL take priority over a simultaneous start.

Verification
REQ-035 LUI: XLEN=32, instruction 0x123450B7, start -> next cycle wb_valid = 1, output_register = 1, data = 0x12345000, alu_req never 1.
REQ-036 AUIPC sign/wrap: XLEN=64, instruction 0xFFFFF117, PC = 0x1000, ALU returns the sum -> alu_b = 0xFFFFFFFFFFFFF000, data = 0x0, output_register = 2.
REQ-037 Grant stall: AUIPC with alu_gnt held 0 for 5 cycles -> alu_req stays 1, operands stable, ready = 0, wb_valid = 0 throughout.
REQ-038 Writeback backpressure: wb_ready held 0 for 3 cycles -> wb_valid and data stable, and a start offered during the stall is ignored.
REQ-039 Reset mid-operation: rst in ALU_WAIT, then alu_valid arrives -> no wb_valid, ready = 1 the cycle after reset.
REQ-040 Illegal and x0: opcode 0110011 -> illegal pulses for 1 cycle; LUI with rd = 0 -> wb_valid never asserted and ready = 1 after one cycle.
